mux_scan_sampler: RTL and testbench

MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

---
 rtl/mux_scan_sampler.sv | 110 +++++++++++
 tb/tb_mux_scan_sampler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - scans a downstream 4:1 mux channel by channel and assembles 4-bit frames
// Each channel is held for SETTLE_CYCLES before a one-cycle sample; completed frames go to a valid/ready holding register.
module mux_scan_sampler #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       mux_o,
    output logic [1:0] sel,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       overrun,
    input  logic       clr_ovr,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] shadow_q, shadow_d;
    logic [3:0] frame_q, frame_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       complete, load, drop;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                ch_d = 2'd0;
                if (enable) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cnt_d = 8'd0;
                if (ch_q != 2'd3) begin
                    shadow_d[ch_q] = mux_o;
                    ch_d           = ch_q + 2'd1;
                    state_d        = SETTLE;
                end else begin
                    // enable is only honoured here so a frame is never cut short
                    complete = 1'b1;
                    ch_d     = 2'd0;
                    state_d  = enable ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = 2'd0;
            end
        endcase
    end

    always_comb begin
        load    = complete && (!valid_q || frame_ready);
        drop    = complete && valid_q && !frame_ready;
        frame_d = load ? {mux_o, shadow_q} : frame_q;
        valid_d = load || (valid_q && !frame_ready);
        ovr_d   = drop || (ovr_q && !clr_ovr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 3'd0;
            frame_q  <= 4'd0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sel         = ch_q;
    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - directed bench for mux_scan_sampler at SETTLE_CYCLES=1 and 3
module tb_mux_scan_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, frame_ready, clr_ovr;
    logic [3:0] mux_in;
    logic       mux_o;
    logic [1:0] sel;
    logic [3:0] frame;
    logic       frame_valid, overrun, busy;

    logic       enable3;
    logic [3:0] mux_in3;
    logic       mux_o3;
    logic [1:0] sel3;
    logic [3:0] frame3;
    logic       frame_valid3, overrun3, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_o  = mux_in[sel];
    assign mux_o3 = mux_in3[sel3];

    mux_scan_sampler #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mux_o(mux_o), .sel(sel),
        .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy)
    );

    mux_scan_sampler #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable3), .mux_o(mux_o3), .sel(sel3),
        .frame(frame3), .frame_valid(frame_valid3), .frame_ready(1'b1),
        .overrun(overrun3), .clr_ovr(1'b0), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; frame_ready = 1'b1; clr_ovr = 1'b0;
        mux_in = 4'b1010; enable3 = 1'b0; mux_in3 = 4'b0110;
        #2;
        check("rst_sel", sel, 0);
        check("rst_frame", frame, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // continuous scan, consumer always ready
        enable = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check("p1_sel", sel, (k / 2) % 4);
            check("p1_valid", frame_valid, (k == 8 || k == 16));
            if (k == 8 || k == 16) check("p1_frame", frame, 4'b1010);
        end
        check("p1_busy", busy, 1);

        // consumer stalls: first frame held, next dropped
        frame_ready = 1'b0;
        mux_in = 4'b0101;
        for (int k = 17; k <= 24; k++) begin
            tick();
            check("p2_valid", frame_valid, 1);
            check("p2_frame", frame, 4'b1010);
            check("p2_ovr", overrun, (k == 24));
        end
        clr_ovr = 1'b1;
        tick();
        check("p2_clr", overrun, 0);
        clr_ovr = 1'b0;
        repeat (6) tick();
        frame_ready = 1'b1;
        tick();
        check("p3_load_valid", frame_valid, 1);
        check("p3_load_frame", frame, 4'b0101);
        check("p3_load_ovr", overrun, 0);
        tick();
        check("p3_consumed", frame_valid, 0);

        // overrun set in the same cycle as clr_ovr wins
        frame_ready = 1'b0;
        repeat (7) tick();
        check("p4_valid", frame_valid, 1);
        repeat (7) tick();
        clr_ovr = 1'b1;
        tick();
        check("p4_ovr_wins", overrun, 1);
        frame_ready = 1'b1;
        tick();
        check("p4_ovr_clr", overrun, 0);
        check("p4_consumed", frame_valid, 0);
        clr_ovr = 1'b0;
        mux_in = 4'b1100;

        // enable dropped during channel 1: frame still finishes
        tick();
        check("p5_sel1", sel, 1);
        enable = 1'b0;
        tick();
        tick();
        check("p5_sel2", sel, 2);
        check("p5_busy", busy, 1);
        tick();
        tick();
        check("p5_sel3", sel, 3);
        tick();
        tick();
        check("p5_idle_busy", busy, 0);
        check("p5_idle_sel", sel, 0);
        check("p5_valid", frame_valid, 1);
        check("p5_frame", frame, 4'b1100);
        tick();
        check("p5_consumed", frame_valid, 0);
        tick();
        check("p5_still_idle", busy, 0);

        // asynchronous reset in the middle of SETTLE
        enable = 1'b1;
        tick();
        tick();
        tick();
        check("p6_sel_pre", sel, 1);
        check("p6_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("p6_rst_sel", sel, 0);
        check("p6_rst_busy", busy, 0);
        check("p6_rst_frame", frame, 0);
        check("p6_rst_valid", frame_valid, 0);
        check("p6_rst_ovr", overrun, 0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check("p6_valid", frame_valid, (k == 8));
            if (k == 0) check("p6_sel0", sel, 0);
        end
        check("p6_frame", frame, 4'b1100);
        enable = 1'b0;

        // SETTLE_CYCLES=3 instance
        enable3 = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            tick();
            check("p7_sel", sel3, (k / 4) % 4);
            check("p7_valid", frame_valid3, (k == 16 || k == 32));
            if (k == 16 || k == 32) check("p7_frame", frame3, 4'b0110);
        end
        check("p7_ovr", overrun3, 0);
        enable3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
